// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, ALU and PC codes, FSM states.
// CTRL_SINGLE_STEP_EN adds the STEP_WAIT state used by single-step builds.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_BZ    = 4'h8;
    localparam logic [3:0] OP_BNZ   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
`ifdef CTRL_SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_JMP,
        CLS_BZ,
        CLS_BNZ,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT
    } op_class_t;

    // Visibility into the sequencer: current state plus the latched destination register.
    typedef struct packed {
        state_t     state;
        logic [3:0] rd;
    } dbg_t;

endpackage

// File: rtl/cpu_op_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and illegal-opcode flag.
// Undefined opcodes decode as NOP with o_illegal set.
module cpu_op_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    always_comb begin
        o_class   = CLS_NOP;
        o_alu_op  = ALU_PASS;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_NOP:   o_class = CLS_NOP;
            OP_ADD:   begin o_class = CLS_ALU; o_alu_op = ALU_ADD; end
            OP_SUB:   begin o_class = CLS_ALU; o_alu_op = ALU_SUB; end
            OP_AND:   begin o_class = CLS_ALU; o_alu_op = ALU_AND; end
            OP_OR:    begin o_class = CLS_ALU; o_alu_op = ALU_OR;  end
            OP_LOAD:  o_class = CLS_LOAD;
            OP_STORE: o_class = CLS_STORE;
            OP_JMP:   o_class = CLS_JMP;
            OP_BZ:    o_class = CLS_BZ;
            OP_BNZ:   o_class = CLS_BNZ;
            OP_HALT:  o_class = CLS_HALT;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer (fetch/decode/exec/mem/writeback) for the 16-bit accumulator CPU.
// Build option CTRL_SINGLE_STEP_EN adds a step input and parks the FSM after every retirement.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [15:0]      instr,
    input  logic             zero_flag,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_ctrl,
    output logic [7:0]       pc_offset,
    output logic             ir_load,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output dbg_t             dbg
);

    state_t           r_state;
    state_t           w_next;
    state_t           w_resume;
    logic [15:0]      r_ir;
    logic [CNT_W-1:0] r_retired;
    op_class_t        w_class;
    logic [2:0]       w_alu_op;
    logic             w_illegal;

    cpu_op_decode u_decode (
        .i_opcode  (r_ir[15:12]),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

`ifdef CTRL_SINGLE_STEP_EN
    assign w_resume = S_STEP_WAIT;
`else
    assign w_resume = S_FETCH;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= instr;
            if (pc_en) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // pc_en is raised in exactly one cycle per instruction, which is what retires it.
    always_comb begin
        w_next     = r_state;
        pc_en      = 1'b0;
        pc_ctrl    = PC_HOLD;
        ir_load    = 1'b0;
        alu_op     = ALU_PASS;
        reg_we     = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = w_resume;
            S_FETCH: begin
                ir_load = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                illegal = w_illegal;
                case (w_class)
                    CLS_ALU, CLS_JMP, CLS_BZ, CLS_BNZ: w_next = S_EXEC;
                    CLS_LOAD, CLS_STORE:               w_next = S_MEM;
                    CLS_HALT:                          w_next = S_HALT;
                    default:                           w_next = S_WB;
                endcase
            end
            S_EXEC: begin
                case (w_class)
                    CLS_ALU: begin
                        alu_op = w_alu_op;
                        w_next = S_WB;
                    end
                    CLS_JMP: begin
                        pc_en   = 1'b1;
                        pc_ctrl = PC_JMP;
                        w_next  = w_resume;
                    end
                    CLS_BZ, CLS_BNZ: begin
                        pc_en   = 1'b1;
                        pc_ctrl = ((w_class == CLS_BZ) == zero_flag) ? PC_JMP : PC_INC;
                        w_next  = w_resume;
                    end
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (w_class == CLS_LOAD) begin
                    dmem_re = 1'b1;
                    if (dmem_ready) w_next = S_WB;
                end else begin
                    dmem_we = 1'b1;
                    if (dmem_ready) begin
                        pc_en   = 1'b1;
                        pc_ctrl = PC_INC;
                        w_next  = w_resume;
                    end
                end
            end
            S_WB: begin
                reg_we  = (w_class == CLS_ALU) || (w_class == CLS_LOAD);
                alu_op  = (w_class == CLS_ALU) ? w_alu_op : ALU_PASS;
                pc_en   = 1'b1;
                pc_ctrl = PC_INC;
                w_next  = w_resume;
            end
            S_HALT: halted = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
            S_STEP_WAIT: if (step) w_next = S_FETCH;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign pc_offset = r_ir[7:0];
    assign retired   = r_retired;
    assign dbg.state = r_state;
    assign dbg.rd    = r_ir[11:8];

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed and random instructions against a per-instruction
// retirement model; a monitor compares each pc_en cycle against the expected record.
module tb_cpu_ctrl_fsm;
  import cpu_pkg::*;

  localparam int CNT_W = 4;
  localparam int W = 26;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0] instr = 16'h0;
  logic zero_flag = 1'b0;
  logic dmem_ready = 1'b0;
  logic pc_en, ir_load, reg_we, dmem_re, dmem_we, halted, illegal;
  logic [1:0] pc_ctrl;
  logic [7:0] pc_offset;
  logic [2:0] alu_op;
  logic [CNT_W-1:0] retired;
  dbg_t dbg;

  cpu_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .zero_flag(zero_flag),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .pc_ctrl(pc_ctrl), .pc_offset(pc_offset),
    .ir_load(ir_load), .alu_op(alu_op), .reg_we(reg_we), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .halted(halted), .illegal(illegal), .retired(retired), .dbg(dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [CNT_W-1:0] ret_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing within cycle budget", name);
  endtask

  // Expected retirement record, from the instruction-level rules:
  // {latency, illegal seen, dmem_re cycles, dmem_we at retire, reg_we, alu_op, pc_ctrl, pc_offset}
  function automatic logic [W-1:0] model(input logic [15:0] w, input logic z, input int d);
    int lat, re;
    logic ill, dwe, rwe;
    logic [2:0] alu;
    logic [1:0] ctrl;
    int op;
    op = int'(w[15:12]);
    lat = 3; re = 0; ill = 0; dwe = 0; rwe = 0; alu = 3'd0; ctrl = 2'b01;
    if (op >= 1 && op <= 4) begin lat = 4; rwe = 1; alu = 3'(op); end
    else if (op == 5) begin lat = 4 + d; re = d + 1; rwe = 1; end
    else if (op == 6) begin lat = 3 + d; dwe = 1; end
    else if (op == 7) ctrl = 2'b10;
    else if (op == 8) ctrl = z ? 2'b10 : 2'b01;
    else if (op == 9) ctrl = z ? 2'b01 : 2'b10;
    else if (op >= 10 && op <= 14) ill = 1;
    return {6'(lat), ill, 4'(re), dwe, rwe, alu, ctrl, w[7:0]};
  endfunction

  // Monitor: samples 2 time units after the falling edge.
  initial begin
    int lat, re;
    logic ill, in_i, chk_ret;
    logic [W-1:0] e, obs;
    lat = 0; re = 0; ill = 0; in_i = 0; chk_ret = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        in_i = 0; chk_ret = 0; ret_model = '0;
        continue;
      end
      if (chk_ret) begin
        check("retired_count", 32'(retired), 32'(ret_model));
        chk_ret = 0;
      end
      if (!pc_en) check("pc_ctrl_hold", 32'(pc_ctrl), 32'(PC_HOLD));
      if (ir_load) begin in_i = 1; lat = 0; ill = 0; re = 0; end
      if (in_i) begin lat++; ill = ill | illegal; re += int'(dmem_re); end
      if (pc_en) begin
        if (!in_i || exp_q.size() == 0) begin
          fail("unexpected_retire");
        end else begin
          e = exp_q.pop_front();
          obs = {6'(lat), ill, 4'(re), dmem_we, reg_we, alu_op, pc_ctrl, pc_offset};
          check("retire_record", 32'(obs), 32'(e));
          ret_model = ret_model + 1'b1;
          chk_ret = 1;
        end
        in_i = 0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir_load && n < 50) begin @(negedge clk); n++; end
    ok = ir_load;
  endtask

  task automatic exec_instr(input logic [15:0] w, input logic z, input int d);
    int n, mc;
    bit ok;
    wait_fetch(ok);
    if (!ok) begin fail("fetch_timeout"); return; end
    instr = w;
    zero_flag = z;
    exp_q.push_back(model(w, z, d));
    mc = 0; n = 0; ok = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (dmem_re || dmem_we) begin dmem_ready = (mc == d); mc++; end
      else dmem_ready = 1'b0;
      #1;
      if (pc_en) begin ok = 1; break; end
    end
    @(posedge clk);
    #1 dmem_ready = 1'b0;
    if (!ok) fail("retire_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    logic [15:0] w;
    logic [CNT_W-1:0] ret_hold;

    #1;
    check("reset_strobes", 32'({pc_en, pc_ctrl, ir_load, alu_op, reg_we, dmem_re, dmem_we, halted, illegal}), 32'h0);
    check("reset_retired", 32'(retired), 32'h0);
    check("reset_state", 32'(dbg.state), 32'(S_IDLE));
    check("reset_offset", 32'(pc_offset), 32'h0);
    #20;
    @(negedge clk) rst = 1'b1;

    repeat (3) @(negedge clk);
    #2 check("idle_without_start", 32'({dbg.state, ir_load}), 32'({S_IDLE, 1'b0}));

    pulse_start();
    exec_instr(16'h1305, 1'b0, 0);
    exec_instr(16'h8042, 1'b1, 0);
    exec_instr(16'h8042, 1'b0, 0);
    exec_instr(16'h5210, 1'b0, 2);
    exec_instr(16'h6210, 1'b0, 0);
    exec_instr(16'hA000, 1'b0, 0);
    exec_instr(16'h7033, 1'b1, 0);
    exec_instr(16'h9011, 1'b1, 0);
    exec_instr(16'h2477, 1'b0, 0);
    exec_instr(16'h0000, 1'b0, 0);

    // Asynchronous reset while a LOAD waits in MEM.
    wait_fetch(ok);
    if (!ok) fail("fetch_timeout");
    instr = 16'h5210;
    n = 0;
    while (!dmem_re && n < 10) begin @(negedge clk); n++; end
    if (!dmem_re) fail("mem_wait_timeout");
    #3 rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_strobes", 32'({dmem_re, pc_en}), 32'h0);
    check("async_rst_state", 32'(dbg.state), 32'(S_IDLE));
    check("async_rst_retired", 32'(retired), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    pulse_start();
    for (int i = 0; i < 16; i++) exec_instr(16'h0000, 1'b0, 0);
    #1 check("counter_wrap", 32'(retired), 32'h0);

    for (int i = 0; i < 150; i++) begin
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      exec_instr(w, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    // HALT parks the sequencer; start has no effect there.
    wait_fetch(ok);
    if (!ok) fail("fetch_timeout");
    instr = 16'hF000;
    ret_hold = ret_model;
    n = 0;
    while (!halted && n < 10) begin @(negedge clk); #2; n++; end
    if (!halted) fail("halt_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      #2 check("halt_hold", 32'({halted, pc_en, ir_load, reg_we, illegal}), 32'({1'b1, 4'b0000}));
    end
    check("halt_not_retired", 32'(retired), 32'(ret_hold));
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
